mem_arbiter: RTL and testbench

Two-requester arbiter that shares a single mem_ctrl port between the instruction-fetch stage (port 0) and the load/store stage (port 1) of riscv_cpu. It grants the port round-robin, registers and issues one transaction at a time to mem_ctrl, waits for mem_ctrl's completion, and returns read data with a one-cycle done pulse to the granted requester. All outputs are registered.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter sharing one mem_ctrl command port
//            between instruction fetch (port 0) and load/store (port 1).
//            One transaction outstanding at a time, all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                req_rwe_i,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2*DATA_WIDTH-1:0]   req_data_i,
    input  logic [2*DATA_WIDTH/8-1:0] req_sel_i,
    output logic [DATA_WIDTH-1:0]     req_data_o,
    output logic [1:0]                req_done_o,
    output logic [1:0]                mem_rwe_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_data_o,
    output logic [DATA_WIDTH/8-1:0]   mem_sel_o,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    input  logic                      mem_busy_i,
    input  logic                      mem_done_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       last;   // port granted most recently
    logic       grant;  // port owning the outstanding transaction

    logic                  pend0;
    logic                  pend1;
    logic                  pick;
    logic                  pick_wr;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [SEL_WIDTH-1:0]  pick_sel;

    // Grant selection: lone requester wins, a tie goes to the port not granted last
    always_comb begin
        pend0     = |req_rwe_i[1:0];
        pend1     = |req_rwe_i[3:2];
        pick      = (pend0 && pend1) ? ~last : pend1;
        // rwe 2'b11 is a write: only the upper bit decides direction
        pick_wr   = pick ? req_rwe_i[3] : req_rwe_i[1];
        pick_addr = pick ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
        pick_data = pick ? req_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_data_i[DATA_WIDTH-1:0];
        pick_sel  = pick ? req_sel_i[2*SEL_WIDTH-1:SEL_WIDTH]    : req_sel_i[SEL_WIDTH-1:0];
    end

    // Arbitration FSM: issue in IDLE, wait for completion, one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            grant      <= 1'b0;
            req_data_o <= '0;
            req_done_o <= 2'b00;
            mem_rwe_o  <= 2'b00;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_sel_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((pend0 || pend1) && !mem_busy_i) begin
                        grant      <= pick;
                        last       <= pick;
                        mem_rwe_o  <= pick_wr ? 2'b10 : 2'b01;
                        mem_addr_o <= pick_addr;
                        mem_data_o <= pick_data;
                        mem_sel_o  <= pick_sel;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Command is a single-cycle strobe; address/data/sel stay put
                    mem_rwe_o <= 2'b00;
                    if (mem_done_i) begin
                        req_data_o <= mem_data_i;
                        req_done_o <= grant ? 2'b10 : 2'b01;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // No grant here: the requester withdraws on this edge, so
                    // its old request must not be sampled again.
                    req_done_o <= 2'b00;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [3:0]      req_rwe_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_data_i;
    logic [7:0]      req_sel_i;
    logic [DW-1:0]   req_data_o;
    logic [1:0]      req_done_o;
    logic [1:0]      mem_rwe_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [3:0]      mem_sel_o;
    logic [DW-1:0]   mem_data_i;
    logic            mem_busy_i;
    logic            mem_done_i;

    int vec;
    int errs;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rwe_i  (req_rwe_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_sel_i  (req_sel_i),
        .req_data_o (req_data_o),
        .req_done_o (req_done_o),
        .mem_rwe_o  (mem_rwe_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_i (mem_data_i),
        .mem_busy_i (mem_busy_i),
        .mem_done_i (mem_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply reset with all requests idle; returns on a falling edge
    task automatic do_reset();
        rst        = 1'b1;
        req_rwe_i  = '0;
        req_addr_i = '0;
        req_data_i = '0;
        req_sel_i  = '0;
        mem_data_i = '0;
        mem_busy_i = 1'b0;
        mem_done_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a command strobe; n = falling edges waited, -1 on timeout
    task automatic wait_issue(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rwe_o != 2'b00) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({req_data_o, req_done_o, mem_rwe_o, mem_addr_o, mem_data_o, mem_sel_o} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got done=%b rwe=%b addr=%h data=%h rdata=%h sel=%b, want all 0",
                     req_done_o, mem_rwe_o, mem_addr_o, mem_data_o, req_data_o, mem_sel_o);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        req_rwe_i  = 4'b0001;
        req_addr_i = {32'h0, 32'h0000_1000};
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b01 || mem_addr_o !== 32'h0000_1000) begin
            errs++;
            $display("FAIL single_issue: got rwe=%b addr=%h, want 01 00001000", mem_rwe_o, mem_addr_o);
        end
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b00 || mem_addr_o !== 32'h0000_1000) begin
            errs++;
            $display("FAIL single_strobe_len: got rwe=%b addr=%h, want 00 00001000", mem_rwe_o, mem_addr_o);
        end
        repeat (2) @(negedge clk);
        mem_done_i = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_done_i = 1'b0;
        req_rwe_i  = 4'b0000;
        vec++;
        if (req_done_o !== 2'b01 || req_data_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL single_done: got done=%b data=%h, want 01 deadbeef", req_done_o, req_data_o);
        end
        @(negedge clk);
        vec++;
        if (req_done_o !== 2'b00 || mem_rwe_o !== 2'b00) begin
            errs++;
            $display("FAIL single_done_pulse: got done=%b rwe=%b, want 00 00", req_done_o, mem_rwe_o);
        end
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_rwe;
        logic [31:0] exp_addr;
        logic [1:0] exp_done;
        do_reset();
        req_rwe_i  = 4'b1001;
        req_addr_i = {32'h0000_0200, 32'h0000_0100};
        req_data_i = {32'h1234_5678, 32'h0};
        req_sel_i  = 8'b1111_0000;
        for (int k = 0; k < 4; k++) begin
            exp_rwe  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            exp_done = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_issue(n);
            vec++;
            if (n < 0) begin
                errs++;
                $display("FAIL rr_timeout[%0d]: got no issue, want issue within 20 cycles", k);
            end
            vec++;
            if (mem_rwe_o !== exp_rwe || mem_addr_o !== exp_addr) begin
                errs++;
                $display("FAIL rr_grant[%0d]: got rwe=%b addr=%h, want %b %h", k, mem_rwe_o, mem_addr_o, exp_rwe, exp_addr);
            end
            if (k % 2 == 1) begin
                vec++;
                if (mem_data_o !== 32'h1234_5678 || mem_sel_o !== 4'b1111) begin
                    errs++;
                    $display("FAIL rr_wdata[%0d]: got data=%h sel=%b, want 12345678 1111", k, mem_data_o, mem_sel_o);
                end
            end
            mem_done_i = 1'b1;
            mem_data_i = 32'hA000_0000 + k;
            @(negedge clk);
            mem_done_i = 1'b0;
            vec++;
            if (req_done_o !== exp_done || req_data_o !== 32'hA000_0000 + k) begin
                errs++;
                $display("FAIL rr_done[%0d]: got done=%b data=%h, want %b %h", k, req_done_o, req_data_o, exp_done, 32'hA000_0000 + k);
            end
            @(negedge clk);
            vec++;
            if (req_done_o !== 2'b00) begin
                errs++;
                $display("FAIL rr_done_pulse[%0d]: got done=%b, want 00", k, req_done_o);
            end
        end
        req_rwe_i = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy();
        do_reset();
        mem_busy_i = 1'b1;
        req_rwe_i  = 4'b0100;
        req_addr_i = {32'h0000_0300, 32'h0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec++;
            if (mem_rwe_o !== 2'b00) begin
                errs++;
                $display("FAIL busy_hold[%0d]: got rwe=%b, want 00", k, mem_rwe_o);
            end
        end
        mem_busy_i = 1'b0;
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b01 || mem_addr_o !== 32'h0000_0300) begin
            errs++;
            $display("FAIL busy_release: got rwe=%b addr=%h, want 01 00000300", mem_rwe_o, mem_addr_o);
        end
        mem_done_i = 1'b1;
        mem_data_i = 32'h0BAD_F00D;
        @(negedge clk);
        mem_done_i = 1'b0;
        req_rwe_i  = 4'b0000;
        vec++;
        if (req_done_o !== 2'b10 || req_data_o !== 32'h0BAD_F00D) begin
            errs++;
            $display("FAIL busy_done: got done=%b data=%h, want 10 0badf00d", req_done_o, req_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_rwe11_spurious();
        do_reset();
        mem_done_i = 1'b1;
        mem_data_i = 32'h5555_5555;
        @(negedge clk);
        mem_done_i = 1'b0;
        @(negedge clk);
        vec++;
        if (req_done_o !== 2'b00 || mem_rwe_o !== 2'b00 || req_data_o !== 32'h0) begin
            errs++;
            $display("FAIL spurious_done: got done=%b rwe=%b data=%h, want 00 00 0", req_done_o, mem_rwe_o, req_data_o);
        end
        req_rwe_i  = 4'b1100;
        req_addr_i = {32'h0000_0400, 32'h0};
        req_data_i = {32'hFEED_0001, 32'h0};
        req_sel_i  = 8'b0011_0000;
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b10 || mem_addr_o !== 32'h0000_0400 || mem_data_o !== 32'hFEED_0001 || mem_sel_o !== 4'b0011) begin
            errs++;
            $display("FAIL rwe11_issue: got rwe=%b addr=%h data=%h sel=%b, want 10 00000400 feed0001 0011",
                     mem_rwe_o, mem_addr_o, mem_data_o, mem_sel_o);
        end
        mem_done_i = 1'b1;
        @(negedge clk);
        mem_done_i = 1'b0;
        req_rwe_i  = 4'b0000;
        vec++;
        if (req_done_o !== 2'b10) begin
            errs++;
            $display("FAIL rwe11_done: got done=%b, want 10", req_done_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        req_rwe_i  = 4'b0001;
        req_addr_i = {32'h0, 32'h0000_0500};
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b01) begin
            errs++;
            $display("FAIL rst_wait_issue: got rwe=%b, want 01", mem_rwe_o);
        end
        rst       = 1'b1;
        req_rwe_i = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({req_data_o, req_done_o, mem_rwe_o, mem_addr_o, mem_data_o, mem_sel_o} !== '0) begin
            errs++;
            $display("FAIL rst_wait_clear: got done=%b rwe=%b addr=%h, want 00 00 0", req_done_o, mem_rwe_o, mem_addr_o);
        end
        mem_done_i = 1'b1;
        mem_data_i = 32'h7777_7777;
        @(negedge clk);
        mem_done_i = 1'b0;
        @(negedge clk);
        vec++;
        if (req_done_o !== 2'b00 || req_data_o !== 32'h0) begin
            errs++;
            $display("FAIL rst_wait_stale_done: got done=%b data=%h, want 00 0", req_done_o, req_data_o);
        end
        req_rwe_i  = 4'b0001;
        req_addr_i = {32'h0, 32'h0000_0600};
        @(negedge clk);
        vec++;
        if (mem_rwe_o !== 2'b01 || mem_addr_o !== 32'h0000_0600) begin
            errs++;
            $display("FAIL rst_wait_fresh: got rwe=%b addr=%h, want 01 00000600", mem_rwe_o, mem_addr_o);
        end
        mem_done_i = 1'b1;
        mem_data_i = 32'hCAFE_F00D;
        @(negedge clk);
        mem_done_i = 1'b0;
        req_rwe_i  = 4'b0000;
        vec++;
        if (req_done_o !== 2'b01 || req_data_o !== 32'hCAFE_F00D) begin
            errs++;
            $display("FAIL rst_wait_fresh_done: got done=%b data=%h, want 01 cafef00d", req_done_o, req_data_o);
        end
        @(negedge clk);
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_busy();
        test_rwe11_spurious();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
